// File: rtl/magsq_to_mag_if.sv
`default_nettype none
// ============================================================================
// Module      : magsq_to_mag_if
// Description : Stream bundle for the magnitude-squared to magnitude
//               converter. It carries the input stream (2*WIDTH-bit radicand
//               plus tlast) and the output stream (WIDTH-bit magnitude plus
//               tlast), each with a valid/ready handshake.
//               slave  - converter side: consumes i_*, produces o_*
//               master - environment side: produces i_*, consumes o_*
// Revision    : 1.0 - initial release
// ============================================================================
interface magsq_to_mag_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] i_tdata;
  logic               i_tlast;
  logic               i_tvalid;
  logic               i_tready;
  logic [WIDTH-1:0]   o_tdata;
  logic               o_tlast;
  logic               o_tvalid;
  logic               o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid, o_tready,
    output i_tready, o_tdata, o_tlast, o_tvalid
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid, o_tready,
    input  i_tready, o_tdata, o_tlast, o_tvalid
  );
endinterface
`default_nettype wire

// File: rtl/magsq_to_mag.sv
`default_nettype none
// ============================================================================
// Module      : magsq_to_mag
// Description : Streaming integer square root, o = floor(sqrt(x)) or, with
//               ROUND=1, round-half-up with saturation at 2^WIDTH-1.
//               Digit-by-digit (restoring) square root resolving one root bit
//               per clock; one sample in flight at a time.
// Ports       : clk     - clock
//               reset_n - asynchronous active-low reset
//               clear   - synchronous flush, discards any sample in flight
//               bus     - slave side of magsq_to_mag_if (i_* in, o_* out)
// Revision    : 1.0 - initial release
// ============================================================================
module magsq_to_mag #(
  parameter int WIDTH = 16,
  parameter int ROUND = 0
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          clear,
  magsq_to_mag_if.slave      bus
);

  localparam int             CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]  r_x;       // radicand, consumed two bits per cycle from the top
  logic [WIDTH+1:0]    r_rem;
  logic [WIDTH-1:0]    r_root;
  logic                r_last;
  logic [WIDTH-1:0]    r_out_data;
  logic                r_out_last;
  logic                r_out_valid;

  logic [WIDTH+1:0]    w_rem_shift;
  logic [WIDTH+1:0]    w_trial;
  logic                w_ge;
  logic [WIDTH+1:0]    w_rem_next;
  logic [WIDTH-1:0]    w_root_next;
  logic                w_round_up;
  logic [WIDTH-1:0]    w_result;

  // One restoring step: bring down the next radicand digit pair and try
  // appending a 1 to the root (trial subtrahend is 4*root+1). The stored
  // remainder never exceeds 2*root, so the shift below loses no bits.
  always_comb begin
    w_rem_shift = (r_rem << 2) | (WIDTH + 2)'(r_x[2*WIDTH-1 -: 2]);
    w_trial     = {r_root, 2'b01};
    w_ge        = (w_rem_shift >= w_trial);
    w_rem_next  = w_ge ? (w_rem_shift - w_trial) : w_rem_shift;
    w_root_next = (r_root << 1) | WIDTH'(w_ge);
  end

  // (r+0.5)^2 = r^2 + r + 0.25, so rem > r is exactly "round up".
  // An all-ones root cannot be incremented and is left saturated.
  always_comb begin
    w_round_up = (ROUND != 0) &&
                 (w_rem_next > {2'b00, w_root_next}) &&
                 !(&w_root_next);
    w_result   = w_root_next + WIDTH'(w_round_up);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_last      <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_rem       <= '0;
      r_root      <= '0;
      r_last      <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // i_tready is 1 throughout IDLE once out of reset
          if (bus.i_tvalid) begin
            r_x     <= bus.i_tdata;
            r_last  <= bus.i_tlast;
            r_rem   <= '0;
            r_root  <= '0;
            r_cnt   <= C_CNT_INIT;
            r_state <= S_CALC;
          end
        end
        S_CALC: begin
          r_x    <= r_x << 2;
          r_rem  <= w_rem_next;
          r_root <= w_root_next;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            r_out_data  <= w_result;
            r_out_last  <= r_last;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.o_tready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.i_tready = (r_state == S_IDLE) && reset_n;
  assign bus.o_tdata  = r_out_data;
  assign bus.o_tlast  = r_out_last;
  assign bus.o_tvalid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_magsq_to_mag.sv
`default_nettype none
// ============================================================================
// Module      : tb_magsq_to_mag
// Description : Testbench for magsq_to_mag. A truncating and a rounding
//               instance run in lockstep from the same stimulus; every output
//               transfer is checked against an integer square-root model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_magsq_to_mag;

  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_acc = 0;
  int n_xfer = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  magsq_to_mag_if #(.WIDTH(WIDTH)) bus_trunc ();
  magsq_to_mag_if #(.WIDTH(WIDTH)) bus_round ();

  assign bus_trunc.i_tdata  = in_data;
  assign bus_trunc.i_tlast  = in_last;
  assign bus_trunc.i_tvalid = in_valid;
  assign bus_trunc.o_tready = out_ready;
  assign bus_round.i_tdata  = in_data;
  assign bus_round.i_tlast  = in_last;
  assign bus_round.i_tvalid = in_valid;
  assign bus_round.o_tready = out_ready;

  magsq_to_mag #(.WIDTH(WIDTH), .ROUND(0)) u_dut_trunc (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_trunc.slave)
  );
  magsq_to_mag #(.WIDTH(WIDTH), .ROUND(1)) u_dut_round (
    .clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_round.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint isqrt(input longint x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic logic [15:0] model_floor(input logic [31:0] x);
    return 16'(isqrt(longint'(x)));
  endfunction

  function automatic logic [15:0] model_round(input logic [31:0] x);
    longint r, rem;
    r   = isqrt(longint'(x));
    rem = longint'(x) - r * r;
    if (rem > r) r = r + 1;
    if (r > 65535) r = 65535;
    return 16'(r);
  endfunction

  typedef struct {
    logic [15:0] f;
    logic [15:0] r;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   acc_cyc = 0;
  bit   acc_pending = 0;
  bit   prev_valid = 0;

  // Monitor: samples on the falling edge, predicting what the next rising
  // edge does with the handshake signals that are stable now.
  always @(negedge reset_n) begin
    exp_q.delete();
    acc_pending = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (clear) begin
        exp_q.delete();
        acc_pending = 0;
      end else begin
        // accept is seen one falling edge before the handshake edge
        if (bus_trunc.o_tvalid && !prev_valid && acc_pending) begin
          check("latency", 32'(cyc - acc_cyc), 32'(WIDTH + 1));
          acc_pending = 0;
        end
        if (bus_trunc.o_tvalid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("spurious_out", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            check("data_trunc", 32'(bus_trunc.o_tdata), 32'(e.f));
            check("data_round", 32'(bus_round.o_tdata), 32'(e.r));
            check("last_trunc", 32'(bus_trunc.o_tlast), 32'(e.last));
            check("valid_round", 32'(bus_round.o_tvalid), 32'(1));
          end
          n_xfer++;
        end
        if (in_valid && bus_trunc.i_tready) begin
          e.f = model_floor(in_data);
          e.r = model_round(in_data);
          e.last = in_last;
          exp_q.push_back(e);
          acc_cyc = cyc;
          acc_pending = 1;
          n_acc++;
        end
      end
    end
    prev_valid = bus_trunc.o_tvalid;
  end

  // ---------------- stimulus helpers ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [31:0] x, input logic last, output int acc_at);
    int t = 0;
    in_data  = x;
    in_last  = last;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (!bus_trunc.i_tready && t < 400);
    if (t >= 400) check("send_timeout", 32'(1), 32'(0));
    acc_at = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while ((exp_q.size() != 0 || bus_trunc.o_tvalid) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) check("drain_timeout", 32'(1), 32'(0));
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int limit);
    int t = 0;
    while (!bus_trunc.o_tvalid && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) check("valid_timeout", 32'(1), 32'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rand_x();
    logic [31:0] k;
    case ($urandom_range(7))
      0: begin
        k = 32'($urandom_range(65535));
        case ($urandom_range(4))
          0: return 32'(0);
          1: return 32'hFFFF_FFFF;
          2: return k * k;
          3: return k * k + k;
          default: return k * k + k + 1;
        endcase
      end
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] dir_x[7] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd100, 32'h3FFF_0001, 32'hFFFF_FFFF};
  logic [31:0] pkt_x[4] = '{32'd49, 32'd64, 32'd81, 32'd121};

  initial begin
    int a, a_prev, bad, xf;
    bit done;

    // reset state
    #2;
    check("rst_tready", 32'(bus_trunc.i_tready), 32'(0));
    check("rst_tvalid", 32'(bus_trunc.o_tvalid), 32'(0));
    check("rst_tdata",  32'(bus_trunc.o_tdata),  32'(0));
    check("rst_tlast",  32'(bus_round.o_tlast),  32'(0));
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("tready_after_rst", 32'(bus_trunc.i_tready), 32'(1));
    @(posedge clk); #1;

    // directed values, back-to-back with continuous o_tready
    out_ready = 1'b1;
    a_prev = 0;
    for (int i = 0; i < 7; i++) begin
      send(dir_x[i], 1'b0, a);
      if (i > 0) check("accept_spacing", 32'(a - a_prev), 32'(WIDTH + 2));
      a_prev = a;
    end
    wait_drain(100);
    // rounding boundaries
    send(32'd6, 1'b0, a);
    wait_drain(100);

    // backpressure
    out_ready = 1'b0;
    send(32'd144, 1'b0, a);
    wait_valid(100);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus_trunc.o_tvalid || bus_trunc.o_tdata != 16'd12 || bus_trunc.i_tready) bad++;
    end
    check("bp_hold", 32'(bad), 32'(0));
    xf = n_xfer;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_tready_next", 32'(bus_trunc.i_tready), 32'(1));
    check("bp_valid_drop", 32'(bus_trunc.o_tvalid), 32'(0));
    check("bp_one_xfer", 32'(n_xfer - xf), 32'(1));
    @(posedge clk); #1;

    // packet with tlast on the last sample
    for (int i = 0; i < 4; i++) send(pkt_x[i], (i == 3), a);
    wait_drain(100);

    // reset mid-CALC
    send(32'd1000, 1'b0, a);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(bus_trunc.o_tvalid), 32'(0));
    check("midrst_tready", 32'(bus_trunc.i_tready), 32'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(32'd225, 1'b0, a);
    wait_drain(100);

    // clear in OUT together with o_tready
    out_ready = 1'b0;
    send(32'd400, 1'b0, a);
    wait_valid(100);
    xf = n_xfer;
    clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    check("clr_tvalid", 32'(bus_trunc.o_tvalid), 32'(0));
    check("clr_tready", 32'(bus_trunc.i_tready), 32'(1));
    check("clr_no_xfer", 32'(n_xfer - xf), 32'(0));
    @(posedge clk); #1;
    send(32'd4, 1'b0, a);
    wait_drain(100);

    // randomized stream with gaps and backpressure
    done = 0;
    xf = n_xfer;
    a_prev = n_acc;
    fork
      begin
        for (int i = 0; i < 2500; i++) begin
          repeat ($urandom_range(2)) begin @(posedge clk); #1; end
          send(rand_x(), 1'($urandom_range(1)), a);
        end
        wait_drain(2000);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    check("rand_count", 32'(n_xfer - xf), 32'(n_acc - a_prev));
    check("queue_empty", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
